// File: rtl/data_interlayer.sv
// Data-side memory interlayer between MA and WB: aligns stores, drives a single
// outstanding SRAM-like bus transaction and holds load data until WB consumes it.
module data_interlayer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_align_store,
  output logic [31:0] mem_data,
  output logic        interlayer_ready,
  input  logic        rsp_ack,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

  state_t      state, next_state;
  logic        accept;
  logic [1:0]  a;
  logic [31:0] d;
  logic [31:0] word_addr;
  logic [1:0]  al_size;
  logic [31:0] al_addr;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;

  // A response slot frees up in the same cycle WB acknowledges it.
  always_comb begin
    req_ready = (state == IDLE) || ((state == RSP) && rsp_ack);
    accept    = req_valid && req_ready;
  end

  always_comb begin
    a         = req_addr[1:0];
    d         = req_wdata;
    word_addr = {req_addr[31:2], 2'b00};
    al_addr   = req_addr;
    al_size   = 2'd2;
    al_wdata  = '0;
    al_wstrb  = '0;
    if (!req_wen) begin
      al_addr = word_addr;
    end else begin
      case (req_align_store)
        5'b10000: begin
          al_wdata = d;
          al_wstrb = 4'b1111;
        end
        5'b01000: begin
          al_size  = 2'd0;
          al_wdata = {4{d[7:0]}};
          al_wstrb = 4'b0001 << a;
        end
        5'b00100: begin
          al_size  = 2'd1;
          al_wdata = {2{d[15:0]}};
          al_wstrb = a[1] ? 4'b1100 : 4'b0011;
        end
        5'b00010: begin
          al_addr = word_addr;
          case (a)
            2'd0: begin al_wstrb = 4'b0001; al_wdata = {24'b0, d[31:24]}; end
            2'd1: begin al_wstrb = 4'b0011; al_wdata = {16'b0, d[31:16]}; end
            2'd2: begin al_wstrb = 4'b0111; al_wdata = {8'b0, d[31:8]};   end
            2'd3: begin al_wstrb = 4'b1111; al_wdata = d;                 end
          endcase
        end
        5'b00001: begin
          al_addr = word_addr;
          case (a)
            2'd0: begin al_wstrb = 4'b1111; al_wdata = d;                 end
            2'd1: begin al_wstrb = 4'b1110; al_wdata = {d[23:0], 8'b0};   end
            2'd2: begin al_wstrb = 4'b1100; al_wdata = {d[15:0], 16'b0};  end
            2'd3: begin al_wstrb = 4'b1000; al_wdata = {d[7:0], 24'b0};   end
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // data_data_ok only counts once the address phase has completed (WAIT).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept)       next_state = REQ;
      REQ:  if (data_addr_ok) next_state = WAIT;
      WAIT: if (data_data_ok) next_state = data_wr ? IDLE : RSP;
      RSP:  if (rsp_ack)      next_state = req_valid ? REQ : IDLE;
      default:                next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_req         <= 1'b0;
      data_wr          <= 1'b0;
      data_size        <= '0;
      data_addr        <= '0;
      data_wdata       <= '0;
      data_wstrb       <= '0;
      interlayer_ready <= 1'b0;
      mem_data         <= '0;
    end else begin
      data_req         <= (next_state == REQ);
      interlayer_ready <= (next_state == RSP);
      if (accept) begin
        data_wr    <= req_wen;
        data_size  <= al_size;
        data_addr  <= al_addr;
        data_wdata <= al_wdata;
        data_wstrb <= al_wstrb;
      end
      if ((state == WAIT) && data_data_ok && !data_wr)
        mem_data <= data_rdata;
    end
  end

endmodule

// File: tb/tb_data_interlayer.sv
// Scoreboard bench for data_interlayer: expected bus requests and read responses
// are queued when stimulus is driven and compared when the DUT produces them.
module tb_data_interlayer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_align_store;
  logic [31:0] mem_data;
  logic        interlayer_ready;
  logic        rsp_ack;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    bit          chk_addr;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rsp_q[$];
  int          checks = 0;
  int          errors = 0;

  localparam logic [4:0] SW = 5'b10000, SB = 5'b01000, SH = 5'b00100,
                         SWL = 5'b00010, SWR = 5'b00001;

  data_interlayer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_align_store(req_align_store),
    .mem_data(mem_data), .interlayer_ready(interlayer_ready), .rsp_ack(rsp_ack),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference alignment expressed as shifts of a full-word mask and data.
  function automatic bus_t model(input logic wen, input logic [31:0] addr,
                                 input logic [31:0] d, input logic [4:0] align);
    bus_t e;
    int   a;
    a = int'(addr[1:0]);
    e.wr = wen; e.size = 2'd2; e.addr = addr; e.wdata = '0; e.strb = '0; e.chk_addr = 1'b1;
    if (!wen) begin
      e.addr = addr & ~32'h3;
    end else if (align == SW) begin
      e.wdata = d; e.strb = 4'hF;
    end else if (align == SB) begin
      e.size = 2'd0; e.wdata = {4{d[7:0]}}; e.strb = 4'h1 << a;
    end else if (align == SH) begin
      e.size = 2'd1; e.wdata = {2{d[15:0]}}; e.strb = (a >= 2) ? 4'hC : 4'h3;
    end else if (align == SWL) begin
      e.addr = addr & ~32'h3; e.wdata = d >> (8 * (3 - a)); e.strb = 4'hF >> (3 - a);
    end else if (align == SWR) begin
      e.addr = addr & ~32'h3; e.wdata = d << (8 * a); e.strb = 4'hF << a;
    end else begin
      e.chk_addr = 1'b0;
    end
    return e;
  endfunction

  task automatic driveReq(input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] align);
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wdata; req_align_store = align;
    bus_q.push_back(model(wen, addr, wdata, align));
  endtask

  task automatic issueReq(input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] align);
    driveReq(wen, addr, wdata, align);
    checkOutput("req_ready_idle", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic checkBus(input bus_t e);
    checkOutput("data_req", 32'(data_req), 1);
    checkOutput("data_wr", 32'(data_wr), 32'(e.wr));
    if (e.chk_addr) begin
      checkOutput("data_addr", data_addr, e.addr);
      checkOutput("data_size", 32'(data_size), 32'(e.size));
    end
    checkOutput("data_wdata", data_wdata, e.wdata);
    checkOutput("data_wstrb", 32'(data_wstrb), 32'(e.strb));
  endtask

  task automatic busPhase(input int addr_wait, input int data_wait,
                          input logic [31:0] rdata, input bit spur);
    bus_t e;
    if (bus_q.size() == 0) begin
      checkOutput("bus_q_empty", 1, 0);
      return;
    end
    e = bus_q.pop_front();
    for (int i = 0; i <= addr_wait; i++) begin
      checkBus(e);
      checkOutput("req_ready_req", 32'(req_ready), 0);
      checkOutput("ir_req", 32'(interlayer_ready), 0);
      if (i < addr_wait) begin
        data_data_ok = spur && (i == 0);
        @(negedge clk);
        data_data_ok = 1'b0;
      end
    end
    data_addr_ok = 1'b1; data_data_ok = spur;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    for (int i = 0; i <= data_wait; i++) begin
      checkOutput("data_req_wait", 32'(data_req), 0);
      checkOutput("ir_wait", 32'(interlayer_ready), 0);
      checkOutput("req_ready_wait", 32'(req_ready), 0);
      if (i < data_wait) @(negedge clk);
    end
    data_data_ok = 1'b1; data_rdata = rdata;
    if (!e.wr) rsp_q.push_back(rdata);
    @(negedge clk);
    data_data_ok = 1'b0; data_rdata = $urandom;
    if (e.wr) begin
      checkOutput("ir_after_store", 32'(interlayer_ready), 0);
      checkOutput("req_ready_after_store", 32'(req_ready), 1);
      checkOutput("data_req_after_store", 32'(data_req), 0);
    end
  endtask

  task automatic rspPhase(input int ack_wait, input bit chain, input logic [31:0] naddr);
    logic [31:0] exp;
    if (rsp_q.size() == 0) begin
      checkOutput("rsp_q_empty", 1, 0);
      return;
    end
    exp = rsp_q.pop_front();
    for (int i = 0; i <= ack_wait; i++) begin
      checkOutput("ir_rsp", 32'(interlayer_ready), 1);
      checkOutput("mem_data", mem_data, exp);
      checkOutput("req_ready_rsp", 32'(req_ready), 0);
      if (i < ack_wait) @(negedge clk);
    end
    rsp_ack = 1'b1;
    if (chain) driveReq(1'b0, naddr, 32'h0, 5'b0);
    #1;
    checkOutput("req_ready_ack", 32'(req_ready), 1);
    @(negedge clk);
    rsp_ack = 1'b0; req_valid = 1'b0;
    checkOutput("ir_after_ack", 32'(interlayer_ready), 0);
    if (!chain) begin
      checkOutput("req_ready_after_ack", 32'(req_ready), 1);
      checkOutput("data_req_after_ack", 32'(data_req), 0);
    end
  endtask

  task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] align, input logic [31:0] rdata,
                               input int addr_wait, input int data_wait, input int ack_wait);
    issueReq(wen, addr, wdata, align);
    busPhase(addr_wait, data_wait, rdata, 1'b0);
    if (!wen) rspPhase(ack_wait, 1'b0, 32'h0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 1);
    checkOutput({tag, "_data_req"}, 32'(data_req), 0);
    checkOutput({tag, "_data_wr"}, 32'(data_wr), 0);
    checkOutput({tag, "_data_size"}, 32'(data_size), 0);
    checkOutput({tag, "_data_addr"}, data_addr, 0);
    checkOutput({tag, "_data_wdata"}, data_wdata, 0);
    checkOutput({tag, "_data_wstrb"}, 32'(data_wstrb), 0);
    checkOutput({tag, "_ir"}, 32'(interlayer_ready), 0);
    checkOutput({tag, "_mem_data"}, mem_data, 0);
  endtask

  initial begin
    logic [4:0] kinds [5];
    bus_t       e;
    kinds = '{SW, SB, SH, SWL, SWR};
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_align_store = '0; rsp_ack = 1'b0; data_addr_ok = 1'b0; data_rdata = '0;
    data_data_ok = 1'b0;
    #1;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] word load, zero wait");
    applyStimulus(1'b0, 32'h1000_0006, 32'h0, 5'b0, 32'hA1B2C3D4, 0, 0, 2);

    $display("[TB] store alignment sweep");
    foreach (kinds[k])
      for (int a = 0; a < 4; a++)
        applyStimulus(1'b1, 32'h2000_0010 + a, 32'h11223344, kinds[k], 32'h0, 0, 0, 0);
    applyStimulus(1'b1, 32'h2000_0021, 32'hDEADBEEF, 5'b0, 32'h0, 0, 0, 0);

    $display("[TB] bus stalls");
    applyStimulus(1'b1, 32'h3000_0002, 32'hCAFEF00D, SH, 32'h0, 4, 3, 0);
    applyStimulus(1'b0, 32'h3000_0103, 32'h0, 5'b0, 32'h5566_7788, 4, 3, 1);

    $display("[TB] response hold and back-to-back");
    issueReq(1'b0, 32'h4000_0000, 32'h0, 5'b0);
    busPhase(0, 0, 32'h0BAD_F00D, 1'b0);
    rspPhase(5, 1'b1, 32'h4000_0009);
    busPhase(0, 1, 32'h1357_9BDF, 1'b0);
    rspPhase(0, 1'b0, 32'h0);

    $display("[TB] spurious inputs");
    data_data_ok = 1'b1; rsp_ack = 1'b1; data_addr_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0; rsp_ack = 1'b0; data_addr_ok = 1'b0;
    checkOutput("spur_idle_data_req", 32'(data_req), 0);
    checkOutput("spur_idle_ir", 32'(interlayer_ready), 0);
    checkOutput("spur_idle_req_ready", 32'(req_ready), 1);
    issueReq(1'b0, 32'h5000_0004, 32'h0, 5'b0);
    busPhase(1, 1, 32'h2468_ACE0, 1'b1);
    rspPhase(0, 1'b0, 32'h0);

    $display("[TB] random transactions");
    for (int n = 0; n < 10; n++)
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, kinds[$urandom_range(0, 4)],
                    $urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));

    $display("[TB] reset mid-WAIT");
    issueReq(1'b0, 32'h6000_0008, 32'h0, 5'b0);
    e = bus_q.pop_front();
    checkBus(e);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    checkOutput("rst_wait_data_req", 32'(data_req), 0);
    #2 rst_n = 1'b0;
    #1;
    checkReset("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ir", 32'(interlayer_ready), 0);
    applyStimulus(1'b1, 32'h7000_0004, 32'h89AB_CDEF, SW, 32'h0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
